// File: rtl/vga_if.sv
// VGA timing/pixel stream bundle: counters, sync/blank strobes and 4:4:4 RGB.
interface vga_if;
  logic [11:0] hcount;
  logic [11:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/capture_rect.sv
// Captures a W x H window of a VGA stream into sprite RAM, passing the stream through with 1 clk
// delay. Optional macro CAPTURE_BORDER_EN draws a red outline around the window while busy.
module capture_rect #(
  parameter int unsigned W = 48,
  parameter int unsigned H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic        busy,
  output logic        done,
  output logic [11:0] mem_addr,
  output logic [11:0] mem_wdata,
  output logic        mem_we,
  vga_if.slave        vga_in,
  vga_if.master       vga_out
);

  typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] xr_q, xr_d, yr_q, yr_d;
  logic        left_q, left_d;
  logic        last_q, last_d;
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d, wdata_q;
  logic [11:0] hc_q, vc_q, rgb_q, rgb_d;
  logic        hs_q, vs_q, hb_q, vb_q;

  logic [12:0] hc13, vc13, xr13, yr13, x_end, y_end;
  logic        frame_origin, active, wrap, in_win, is_last;

  assign hc13  = {1'b0, vga_in.hcount};
  assign vc13  = {1'b0, vga_in.vcount};
  assign xr13  = {1'b0, xr_q};
  assign yr13  = {1'b0, yr_q};
  assign x_end = xr13 + 13'(W);
  assign y_end = yr13 + 13'(H);

  assign frame_origin = (vga_in.hcount == 12'd0) && (vga_in.vcount == 12'd0);
  // The ARMED cycle that sees the frame origin is already treated as capture.
  assign active  = (state_q == StCapture) || ((state_q == StArmed) && frame_origin);
  assign wrap    = (state_q == StCapture) && left_q && (vga_in.vcount == 12'd0);
  assign in_win  = (hc13 >= xr13) && (hc13 < x_end) && (vc13 >= yr13) && (vc13 < y_end);
  assign is_last = (hc13 == x_end - 13'd1) && (vc13 == y_end - 13'd1);

  assign we_d   = active && !wrap && in_win;
  assign last_d = we_d && is_last;
  assign addr_d = we_d ? {6'(vga_in.vcount - yr_q), 6'(vga_in.hcount - xr_q)} : 12'd0;

  always_comb begin
    state_d = state_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    left_d  = left_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          xr_d    = x;
          yr_d    = y;
          left_d  = 1'b0;
          state_d = StArmed;
        end
      end
      StArmed: begin
        if (frame_origin) state_d = StCapture;
      end
      StCapture: begin
        if (vga_in.vcount != 12'd0) left_d = 1'b1;
        // last_q means the final window pixel's write is on the bus this cycle.
        if (last_q || wrap) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy = (state_q == StArmed) || (state_q == StCapture);
  assign done = (state_q == StDone);

`ifdef CAPTURE_BORDER_EN
  logic on_vedge, on_hedge, in_xext, in_yext, border;
  assign on_vedge = (hc13 + 13'd1 == xr13) || (hc13 == x_end);
  assign on_hedge = (vc13 + 13'd1 == yr13) || (vc13 == y_end);
  assign in_xext  = (hc13 + 13'd1 >= xr13) && (hc13 <= x_end);
  assign in_yext  = (vc13 + 13'd1 >= yr13) && (vc13 <= y_end);
  assign border   = busy && ((on_vedge && in_yext) || (on_hedge && in_xext));
  assign rgb_d    = border ? 12'hF00 : vga_in.rgb;
`else
  assign rgb_d = vga_in.rgb;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      xr_q    <= '0;
      yr_q    <= '0;
      left_q  <= 1'b0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      hb_q    <= 1'b0;
      vb_q    <= 1'b0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      left_q  <= left_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= we_d ? vga_in.rgb : 12'd0;
      hc_q    <= vga_in.hcount;
      vc_q    <= vga_in.vcount;
      hs_q    <= vga_in.hsync;
      vs_q    <= vga_in.vsync;
      hb_q    <= vga_in.hblnk;
      vb_q    <= vga_in.vblnk;
      rgb_q   <= rgb_d;
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign vga_out.hcount = hc_q;
  assign vga_out.vcount = vc_q;
  assign vga_out.hsync  = hs_q;
  assign vga_out.vsync  = vs_q;
  assign vga_out.hblnk  = hb_q;
  assign vga_out.vblnk  = vb_q;
  assign vga_out.rgb    = rgb_q;

endmodule

// File: tb/tb_capture_rect.sv
// Scoreboard bench for capture_rect: stimulus queues expected RAM writes, a monitor pops them.
module tb_capture_rect;
  localparam int W = 48;
  localparam int H = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic        busy, done, mem_we;
  logic [11:0] mem_addr, mem_wdata;

  vga_if vin ();
  vga_if vout ();

  capture_rect #(.W(W), .H(H)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .x         (x),
    .y         (y),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .vga_in    (vin),
    .vga_out   (vout)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_pop = 0;
  logic [23:0] exp_q[$];
  bit          cap_on = 1'b0;
  bit          done_ok = 1'b0;
  int          cx = 0;
  int          cy = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one pixel, let the DUT sample it, then check the pass-through stream.
  task automatic drive(input int h, input int v, input bit st = 1'b0);
    logic        rst_s;
    logic [39:0] exp_out;
    vin.hcount = 12'(h);
    vin.vcount = 12'(v);
    vin.hsync  = (h >= 656) && (h < 752);
    vin.vsync  = (v == 490) || (v == 491);
    vin.hblnk  = h >= 640;
    vin.vblnk  = v >= 480;
    vin.rgb    = 12'(h);
    start      = st;
    rst_s      = rst;
    if (cap_on && h >= cx && h < cx + W && v >= cy && v < cy + H)
      exp_q.push_back({12'(((v - cy) << 6) | (h - cx)), 12'(h)});
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_out = rst_s ? {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk,
                       vin.rgb} : 40'd0;
`ifdef CAPTURE_BORDER_EN
    chk("vga_out_timing", {24'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
        vout.vblnk}, {24'd0, exp_out[39:12]});
`else
    chk("vga_out_all", {24'd0, vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk,
        vout.vblnk, vout.rgb}, {24'd0, exp_out});
`endif
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {40'd0, mem_addr, mem_wdata}, 64'd0);
      end else begin
        chk("write_addr_data", {40'd0, mem_addr, mem_wdata}, {40'd0, exp_q.pop_front()});
        n_pop++;
      end
    end
    if (done === 1'b1) chk("done_expected", 64'(done_ok), 64'd1);
  end

  task automatic run_full(input bit with_ignore);
    x = 12'd100;
    y = 12'd50;
    drive(5, 300, 1'b1);
    x = 12'd0;
    y = 12'd0;
    chk("busy_after_start", 64'(busy), 64'd1);
    drive(120, 60);
    drive(799, 599);
    chk("busy_while_armed", 64'(busy), 64'd1);
    cap_on = 1'b1;
    cx     = 100;
    cy     = 50;
    n_pop  = 0;
    drive(0, 0);
    for (int v = 50; v <= 113; v++) begin
      for (int h = 98; h <= 150; h++) begin
        drive(h, v, with_ignore && v == 80 && h == 98);
        if (h == 100 && v == 50) begin
          chk("first_write", {52'd0, mem_we, mem_addr}, {52'd0, 1'b1, 12'h000});
          chk("first_data", 64'(mem_wdata), 64'd100);
        end
        if (h == 99 && v == 50) begin
`ifdef CAPTURE_BORDER_EN
          chk("border_99_50", 64'(vout.rgb), 64'h0F00);
`else
          chk("rgb_99_50", 64'(vout.rgb), 64'd99);
`endif
        end
        if (h == 120 && v == 80) chk("busy_mid", 64'(busy), 64'd1);
        if (h == 147 && v == 113) begin
          chk("last_write", {52'd0, mem_we, mem_addr}, {52'd0, 1'b1, 12'hFEF});
          chk("last_data", 64'(mem_wdata), 64'd147);
          chk("no_done_on_last", {62'd0, done, busy}, 64'b01);
          done_ok = 1'b1;
        end
        if (h == 148 && v == 113) begin
          chk("done_pulse", {62'd0, done, busy}, 64'b10);
`ifdef CAPTURE_BORDER_EN
          chk("border_148_113", 64'(vout.rgb), 64'h0F00);
`else
          chk("rgb_148_113", 64'(vout.rgb), 64'd148);
`endif
        end
        if (h == 149 && v == 113) begin
          chk("done_single", {62'd0, done, busy}, 64'b00);
          done_ok = 1'b0;
        end
      end
    end
    cap_on = 1'b0;
    chk("write_count_full", 64'(n_pop), 64'd3072);
    chk("queue_empty_full", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: timeout reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    drive(5, 7);
    drive(6, 7);
    chk("reset_outputs", {36'd0, busy, done, mem_we, mem_addr, mem_wdata, 1'b0},
        {36'd0, 3'b000, 12'd0, 12'd0, 1'b0});
    rst = 1'b1;
    drive(7, 3);
    drive(700, 495);
    chk("idle_no_busy", {62'd0, busy, mem_we}, 64'd0);

    run_full(1'b1);

    // Window clipped by frame end: only 20x20 pixels exist, done on vcount wrap.
    x = 12'd780;
    y = 12'd580;
    drive(10, 400, 1'b1);
    x = 12'd0;
    y = 12'd0;
    chk("busy_clip_start", 64'(busy), 64'd1);
    cap_on = 1'b1;
    cx     = 780;
    cy     = 580;
    n_pop  = 0;
    drive(0, 0);
    for (int v = 578; v <= 599; v++)
      for (int h = 778; h <= 799; h++) drive(h, v);
    chk("busy_before_wrap", 64'(busy), 64'd1);
    done_ok = 1'b1;
    drive(0, 0);
    chk("done_on_wrap", {61'd0, done, busy, mem_we}, 64'b100);
    drive(1, 0);
    chk("done_wrap_single", 64'(done), 64'd0);
    done_ok = 1'b0;
    cap_on  = 1'b0;
    chk("write_count_clip", 64'(n_pop), 64'd400);
    chk("queue_empty_clip", 64'(exp_q.size()), 64'd0);

    // Reset during row 10 of the window abandons the capture.
    x = 12'd100;
    y = 12'd50;
    drive(3, 200, 1'b1);
    cap_on = 1'b1;
    cx     = 100;
    cy     = 50;
    n_pop  = 0;
    drive(0, 0);
    for (int v = 50; v <= 59; v++)
      for (int h = 98; h <= 150; h++) drive(h, v);
    for (int h = 98; h <= 119; h++) drive(h, 60);
    cap_on = 1'b0;
    rst    = 1'b0;
    drive(120, 60);
    chk("reset_mid_capture", {36'd0, busy, done, mem_we, mem_addr, mem_wdata, 1'b0},
        {36'd0, 3'b000, 12'd0, 12'd0, 1'b0});
    rst = 1'b1;
    for (int v = 60; v <= 113; v++)
      for (int h = 98; h <= 150; h++) drive(h, v);
    drive(0, 0);
    drive(1, 0);
    chk("idle_after_reset", {62'd0, busy, done}, 64'd0);
    chk("write_count_reset", 64'(n_pop), 64'd500);
    chk("queue_empty_reset", 64'(exp_q.size()), 64'd0);

    run_full(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
